// File: rtl/mips_pkg.sv
// Shared definitions for the mips_pipeline front end: PC width,
// 2-bit branch counter encodings, the resolved-branch update bundle
// and a saturating 32-bit increment used by the statistics counters.
package mips_pkg;

    localparam int PC_W = 32;

    // 2-bit saturating counter states; the MSB is the taken prediction
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Resolved conditional branch coming back from EX
    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
        logic            mispredict;
    } bp_update_t;

    // Adds one when enabled, but sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
        return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter, one per direction-table entry.
// Counts towards ST on taken and towards SNT on not-taken when enabled.
module sat_counter2
    import mips_pkg::*;
#(
    parameter logic [1:0] INIT = WNT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    output logic [1:0] cnt
);

    logic [1:0] cnt_d;
    logic [1:0] cnt_q;

    // Next count: move one step in the resolved direction, clamped at both ends
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (up && (cnt_q != ST)) begin
                cnt_d = cnt_q + 2'd1;
            end else if (!up && (cnt_q != SNT)) begin
                cnt_d = cnt_q - 2'd1;
            end
        end
    end

    // Counter register, returns to the weakly-biased initial state on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= INIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the IF stage: direct-mapped table of 2-bit
// counters plus a tagged BTB, looked up combinationally on the fetch PC and
// trained by resolved branches from EX. Also counts branches and mispredicts.
// PC_W is expected to match mips_pkg::PC_W since the update bundle uses it.
module branch_predictor #(
    parameter int         PC_W     = 32,
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_mispredict,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    import mips_pkg::*;

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = PC_W - IDX_W - 2;

    bp_update_t       upd;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] upd_tag;

    logic             valid_d  [ENTRIES];
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_d [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic [1:0]       cnt_val  [ENTRIES];

    logic [31:0] stat_branches_d;
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_d;
    logic [31:0] stat_mispredicts_q;

    logic unused_pc_bits;

    // Bundle the EX update and split both PCs into table index and tag
    always_comb begin
        upd.valid      = upd_valid;
        upd.pc         = upd_pc;
        upd.taken      = upd_taken;
        upd.target     = upd_target;
        upd.mispredict = upd_mispredict;
        if_idx         = if_pc[IDX_W+1:2];
        if_tag         = if_pc[PC_W-1:IDX_W+2];
        upd_idx        = upd.pc[IDX_W+1:2];
        upd_tag        = upd.pc[PC_W-1:IDX_W+2];
    end

    assign unused_pc_bits = ^{if_pc[1:0], upd.pc[1:0]};

    // Direction counters train on every resolved branch, taken or not
    for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
        sat_counter2 #(
            .INIT(CNT_INIT)
        ) u_cnt (
            .clk(clk),
            .rst(rst),
            .en (upd.valid && (upd_idx == IDX_W'(g))),
            .up (upd.taken),
            .cnt(cnt_val[g])
        );
    end

    // BTB allocation only on taken branches; aliasing entries are simply overwritten
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (upd.valid && upd.taken) begin
            valid_d[upd_idx]  = 1'b1;
            tag_d[upd_idx]    = upd_tag;
            target_d[upd_idx] = upd.target;
        end
    end

    // Statistics stick at all-ones rather than wrapping on very long runs
    always_comb begin
        stat_branches_d    = sat_inc32(stat_branches_q, upd.valid);
        stat_mispredicts_d = sat_inc32(stat_mispredicts_q, upd.valid && upd.mispredict);
    end

    // BTB arrays and statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    // Lookup reads registered state only, so a same-cycle update is seen next cycle
    always_comb begin
        pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = pred_hit && cnt_val[if_idx][1];
        pred_target = pred_hit ? target_q[if_idx] : '0;
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed scenarios followed by a random
// phase, all checked against a behavioural model of the predictor tables.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int assertCount;
    int failCount;

    // Reference model: plain per-entry arrays and integer counter values
    bit          mValid [64];
    logic [23:0] mTag   [64];
    logic [31:0] mTgt   [64];
    int          mCnt   [64];
    longint      mBranches;
    longint      mMispredicts;

    branch_predictor dut (
        .clk             (clk),
        .rst             (rst),
        .if_pc           (if_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_mispredict  (upd_mispredict),
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic modelReset();
        for (int i = 0; i < 64; i++) begin
            mValid[i] = 1'b0;
            mTag[i]   = '0;
            mTgt[i]   = '0;
            mCnt[i]   = 1;
        end
        mBranches    = 0;
        mMispredicts = 0;
    endtask

    task automatic modelUpdate(bit v, logic [31:0] pc, bit tk, logic [31:0] tg, bit mp);
        int i;
        if (!v) return;
        i = int'(pc[7:2]);
        if (tk) begin
            mCnt[i]   = (mCnt[i] + 1 > 3) ? 3 : mCnt[i] + 1;
            mValid[i] = 1'b1;
            mTag[i]   = pc[31:8];
            mTgt[i]   = tg;
        end else begin
            mCnt[i] = (mCnt[i] - 1 < 0) ? 0 : mCnt[i] - 1;
        end
        if (mBranches < 64'hFFFF_FFFF) mBranches++;
        if (mp && mMispredicts < 64'hFFFF_FFFF) mMispredicts++;
    endtask

    function automatic bit expHit(logic [31:0] pc);
        int i;
        i = int'(pc[7:2]);
        return mValid[i] && (mTag[i] == pc[31:8]);
    endfunction

    function automatic bit expTaken(logic [31:0] pc);
        return expHit(pc) && (mCnt[int'(pc[7:2])] >= 2);
    endfunction

    function automatic logic [31:0] expTarget(logic [31:0] pc);
        return expHit(pc) ? mTgt[int'(pc[7:2])] : 32'h0;
    endfunction

    function automatic logic [31:0] randPc();
        logic [31:0] p;
        if ($urandom_range(0, 7) == 0) begin
            p = $urandom;
        end else begin
            p = {24'($urandom_range(0, 2)), 6'($urandom_range(16, 19)), 2'($urandom_range(0, 3))};
        end
        return p;
    endfunction

    task automatic checkOutput(string name, bit eHit, bit eTaken, logic [31:0] eTarget);
        assertCount++;
        assert (pred_hit === eHit) else begin
            failCount++;
            $error("[TB] FAIL %s pred_hit observed=%0b expected=%0b", name, pred_hit, eHit);
        end
        assertCount++;
        assert (pred_taken === eTaken) else begin
            failCount++;
            $error("[TB] FAIL %s pred_taken observed=%0b expected=%0b", name, pred_taken, eTaken);
        end
        assertCount++;
        assert (pred_target === eTarget) else begin
            failCount++;
            $error("[TB] FAIL %s pred_target observed=%h expected=%h", name, pred_target, eTarget);
        end
    endtask

    task automatic checkStats(string name, logic [31:0] eBr, logic [31:0] eMp);
        assertCount++;
        assert (stat_branches === eBr) else begin
            failCount++;
            $error("[TB] FAIL %s stat_branches observed=%h expected=%h", name, stat_branches, eBr);
        end
        assertCount++;
        assert (stat_mispredicts === eMp) else begin
            failCount++;
            $error("[TB] FAIL %s stat_mispredicts observed=%h expected=%h", name, stat_mispredicts, eMp);
        end
    endtask

    // One clock cycle: drive, check the pre-edge lookup, clock, check the stats
    task automatic applyStimulus(string name, bit v, logic [31:0] pc, bit tk,
                                 logic [31:0] tg, bit mp, logic [31:0] ipc);
        upd_valid      = v;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tg;
        upd_mispredict = mp;
        if_pc          = ipc;
        #1;
        checkOutput(name, expHit(ipc), expTaken(ipc), expTarget(ipc));
        @(posedge clk);
        modelUpdate(v, pc, tk, tg, mp);
        @(negedge clk);
        #1;
        checkStats(name, mBranches[31:0], mMispredicts[31:0]);
    endtask

    // Lookup only, no training this cycle
    task automatic lookup(logic [31:0] ipc);
        upd_valid = 1'b0;
        if_pc     = ipc;
        #1;
    endtask

    initial begin
        assertCount    = 0;
        failCount      = 0;
        rst            = 1'b0;
        if_pc          = 32'h0000_0040;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_taken      = 1'b0;
        upd_target     = '0;
        upd_mispredict = 1'b0;
        modelReset();

        // Reset state
        @(negedge clk);
        #1;
        checkOutput("reset_0x40", 1'b0, 1'b0, 32'h0);
        checkStats("reset", 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        lookup(32'hDEAD_BEEC);
        checkOutput("reset_rand_pc", 1'b0, 1'b0, 32'h0);

        // Training: 01 -> 10 -> 11
        applyStimulus("train1", 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h40);
        applyStimulus("train2", 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h40);
        lookup(32'h40);
        checkOutput("train_done", 1'b1, 1'b1, 32'h100);
        checkStats("train_done", 32'd2, 32'd0);

        // Hysteresis: 11 -> 10 still taken, -> 01 not taken, BTB retained
        applyStimulus("hyst1", 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h40);
        lookup(32'h40);
        checkOutput("hyst_one_nt", 1'b1, 1'b1, 32'h100);
        applyStimulus("hyst2", 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h40);
        lookup(32'h40);
        checkOutput("hyst_two_nt", 1'b1, 1'b0, 32'h100);
        applyStimulus("hyst3", 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h40);

        // Aliasing: counter at 00 is inherited (becomes 01, not taken)
        applyStimulus("alias", 1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 32'h140);
        lookup(32'h40);
        checkOutput("alias_old_pc", 1'b0, 1'b0, 32'h0);
        lookup(32'h140);
        checkOutput("alias_new_pc", 1'b1, 1'b0, 32'h200);

        // Same-cycle lookup and update: no bypass
        upd_valid      = 1'b1;
        upd_pc         = 32'h80;
        upd_taken      = 1'b1;
        upd_target     = 32'h300;
        upd_mispredict = 1'b1;
        if_pc          = 32'h80;
        #1;
        checkOutput("same_cycle_pre", 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        modelUpdate(1'b1, 32'h80, 1'b1, 32'h300, 1'b1);
        @(negedge clk);
        lookup(32'h80);
        checkOutput("same_cycle_post", 1'b1, 1'b1, 32'h300);
        checkStats("same_cycle", 32'd7, 32'd1);

        // Random training and lookup against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] upc;
            logic [31:0] ipc;
            upc = randPc();
            ipc = ($urandom_range(0, 3) == 0) ? upc : randPc();
            applyStimulus("random", 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)),
                          $urandom, 1'($urandom_range(0, 1)), ipc);
        end

        // Async reset between edges after training
        applyStimulus("pre_reset", 1'b1, 32'h44, 1'b1, 32'h500, 1'b1, 32'h44);
        if_pc     = 32'h44;
        upd_valid = 1'b0;
        rst       = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 1'b0, 32'h0);
        checkStats("async_reset", 32'h0, 32'h0);
        modelReset();
        rst = 1'b1;
        applyStimulus("post_reset", 1'b1, 32'h44, 1'b1, 32'h600, 1'b0, 32'h44);
        checkStats("post_reset_first_edge", 32'd1, 32'd0);

        // Statistics saturation
        force dut.stat_branches_q    = 32'hFFFF_FFFF;
        force dut.stat_mispredicts_q = 32'hFFFF_FFFF;
        #1;
        release dut.stat_branches_q;
        release dut.stat_mispredicts_q;
        mBranches    = 64'hFFFF_FFFF;
        mMispredicts = 64'hFFFF_FFFF;
        applyStimulus("saturate", 1'b1, 32'h48, 1'b0, 32'h0, 1'b1, 32'h44);
        checkStats("saturate_const", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
